// File: rtl/output_writer.sv
// output_writer: receive-side packet buffer for the SRIO UDP data path.
//
// Stores one packet of payload beats in an internal RAM while counting its byte
// length from the keep lanes, then replays it as a first/last/keep stream under
// ready backpressure. Only one packet is held at a time.
//
// Optional feature (compile-time macro OUTPUT_WRITER_LEN_CHECK_EN): data_len_in
// is latched on the first beat and compared with the counted length at ACK; a
// mismatch pulses err_o together with ack_o.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   data_*_in             receive beat stream (valid/first/last/keep/len)
//   data_ready_out        high while a packet can be accepted (IDLE/WRITE)
//   ack_o                 one-cycle pulse when the packet is fully stored
//   err_o                 one-cycle pulse on overflow, restart or length mismatch
//   output_t*             replay stream, output_tready_in is the user-side ready
//   output_data_len       counted byte length, stable from ack_o to output_done
//   output_done           one-cycle pulse after the final output handshake
module output_writer #(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned DATA_LENGTH_WIDTH = 20,
    parameter int unsigned RAM_ADDR_WIDTH    = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         data_valid_in,
    input  logic                         data_first_in,
    input  logic                         data_last_in,
    input  logic [DATA_WIDTH/8-1:0]      data_keep_in,
    input  logic [DATA_LENGTH_WIDTH-1:0] data_len_in,
    output logic                         data_ready_out,
    output logic                         ack_o,
    output logic                         err_o,
    input  logic                         output_tready_in,
    output logic [DATA_WIDTH-1:0]        output_tdata,
    output logic                         output_tvalid,
    output logic [DATA_WIDTH/8-1:0]      output_tkeep,
    output logic                         output_tfirst,
    output logic                         output_tlast,
    output logic [DATA_LENGTH_WIDTH-1:0] output_data_len,
    output logic                         output_done
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned DEPTH      = 2 ** RAM_ADDR_WIDTH;

    // Beat counters carry one extra bit so a completely full buffer is representable.
    typedef logic [RAM_ADDR_WIDTH:0] cnt_t;
    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

    typedef enum logic [1:0] {StIdle, StWrite, StAck, StRead} state_t;

    state_t                         state_q, state_d;
    logic [DATA_WIDTH-1:0]          mem [DEPTH];
    cnt_t                           wr_cnt_q, rd_cnt_q;
    logic [DATA_LENGTH_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
    logic [KEEP_WIDTH-1:0]          last_keep_q;
    logic                           ovf_q, err_q, done_q;
    logic                           out_valid_q, out_first_q, out_last_q;
    logic [DATA_WIDTH-1:0]          out_data_q;
    logic [KEEP_WIDTH-1:0]          out_keep_q;

    logic                           beat_acc, start, restart, cont, room, wr_en, ovf_evt, close;
    logic [RAM_ADDR_WIDTH-1:0]      wr_addr;
    logic [DATA_LENGTH_WIDTH:0]     byte_sum;
    logic                           pop, rd_en, rd_is_last, read_done, len_err;

    function automatic logic [DATA_LENGTH_WIDTH:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [DATA_LENGTH_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            c = c + {{DATA_LENGTH_WIDTH{1'b0}}, k[i]};
        end
        return c;
    endfunction

    always_comb begin
        beat_acc = data_valid_in & data_ready_out;
        start    = beat_acc & data_first_in & ((state_q == StIdle) | (state_q == StWrite));
        restart  = beat_acc & data_first_in & (state_q == StWrite);
        cont     = beat_acc & ~data_first_in & (state_q == StWrite);
        room     = (wr_cnt_q != DEPTH_CNT);
        wr_en    = start | (cont & room);
        wr_addr  = start ? '0 : wr_cnt_q[RAM_ADDR_WIDTH-1:0];
        // Only the first dropped beat of a packet reports an error.
        ovf_evt  = cont & ~room & ~ovf_q;
        close    = (start | cont) & data_last_in;

        // Saturating byte count; a first beat restarts the count from zero.
        byte_sum   = {1'b0, (start ? '0 : byte_cnt_q)} + popcount(data_keep_in);
        byte_cnt_d = byte_sum[DATA_LENGTH_WIDTH] ? '1 : byte_sum[DATA_LENGTH_WIDTH-1:0];

        // The output register doubles as the RAM read register: a read is issued
        // whenever it is empty or being emptied, so stalls simply hold it.
        pop        = out_valid_q & output_tready_in;
        rd_en      = ((state_q == StAck) | (state_q == StRead)) & (~out_valid_q | pop) &
                     (rd_cnt_q != wr_cnt_q);
        rd_is_last = (rd_cnt_q == wr_cnt_q - cnt_t'(1));
        read_done  = (state_q == StRead) & pop & out_last_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = data_last_in ? StAck : StWrite;
            StWrite: if (close) state_d = StAck;
            StAck:   state_d = StRead;
            StRead:  if (read_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Packet RAM, no reset: contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            byte_cnt_q  <= '0;
            last_keep_q <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                wr_cnt_q    <= cnt_t'(1);
                byte_cnt_q  <= byte_cnt_d;
                last_keep_q <= data_keep_in;
                ovf_q       <= 1'b0;
            end else if (cont & room) begin
                wr_cnt_q    <= wr_cnt_q + cnt_t'(1);
                byte_cnt_q  <= byte_cnt_d;
                last_keep_q <= data_keep_in;
            end else if (ovf_evt) begin
                ovf_q <= 1'b1;
            end
            err_q  <= restart | ovf_evt;
            done_q <= read_done;

            if (close) begin
                rd_cnt_q <= '0;
            end else if (rd_en) begin
                rd_cnt_q <= rd_cnt_q + cnt_t'(1);
            end

            if (rd_en) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mem[rd_cnt_q[RAM_ADDR_WIDTH-1:0]];
                out_first_q <= (rd_cnt_q == '0);
                out_last_q  <= rd_is_last;
                out_keep_q  <= rd_is_last ? last_keep_q : '1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef OUTPUT_WRITER_LEN_CHECK_EN
    logic [DATA_LENGTH_WIDTH-1:0] exp_len_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_len_q <= '0;
        end else if (start) begin
            exp_len_q <= data_len_in;
        end
    end

    assign len_err = (state_q == StAck) & (exp_len_q != byte_cnt_q);
`else
    logic unused_len;
    assign unused_len = ^data_len_in;
    assign len_err    = 1'b0;
`endif

    assign data_ready_out  = (state_q == StIdle) | (state_q == StWrite);
    assign ack_o           = (state_q == StAck);
    assign err_o           = err_q | len_err;
    assign output_tvalid   = out_valid_q;
    assign output_tdata    = out_data_q;
    assign output_tkeep    = out_keep_q;
    assign output_tfirst   = out_first_q;
    assign output_tlast    = out_last_q;
    assign output_data_len = byte_cnt_q;
    assign output_done     = done_q;

endmodule

// File: doc/output_writer.md
# output_writer

Receive-side packet buffer for the SRIO UDP data path: the write-side counterpart of the transmit-side packet reader. Accepts one packet of payload beats from the SRIO receive logic, stores it in an internal RAM and counts its byte length from the keep lanes. It then replays the packet to the user side as a first/last/keep stream under ready backpressure, with the counted byte length alongside. One packet is in flight at a time; the block is not ready for a new packet until the stored one has drained.

## Interface
- DATA_WIDTH, 64: beat width in bits; keep width is DATA_WIDTH/8.
- DATA_LENGTH_WIDTH, 20: byte-length counter and length port width.
- RAM_ADDR_WIDTH, 10: buffer depth is 2^RAM_ADDR_WIDTH beats.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- data_in  in  DATA_WIDTH  receive payload beat.
- data_valid_in  in  1  beat valid.
- data_first_in  in  1  first beat of packet.
- data_last_in  in  1  last beat of packet.
- data_keep_in  in  DATA_WIDTH/8  byte enables; full on all beats except last; last beat MSB-aligned contiguous.
- data_len_in  in  DATA_LENGTH_WIDTH  expected byte length, sampled with first beat (used only under the configuration macro).
- data_ready_out  out  1  block accepts beats.
- ack_o  out  1  one-cycle pulse: packet fully stored.
- err_o  out  1  one-cycle pulse: packet error (overflow, restart, length mismatch).
- output_tready_in  in  1  user-side ready.
- output_tdata  out  DATA_WIDTH  replayed beat.
- output_tvalid  out  1  beat valid.
- output_tkeep  out  DATA_WIDTH/8  all ones except last beat = stored last keep.
- output_tfirst  out  1  first replayed beat.
- output_tlast  out  1  last replayed beat.
- output_data_len  out  DATA_LENGTH_WIDTH  counted byte length; stable from ack_o until output_done.
- output_done  out  1  one-cycle pulse after the final output handshake.

## Operation
- Beat handshake: a beat is accepted when data_valid_in & data_ready_out. Output handshake: output_tvalid & output_tready_in.
- States: IDLE, WRITE, ACK, READ.
- IDLE: data_ready_out=1. Beats without first are ignored. An accepted first beat writes address 0 and initialises the byte count to popcount(keep); go to WRITE. A first+last beat goes directly to ACK.
- WRITE: data_ready_out=1. Each accepted beat writes the next address and adds popcount(keep) to the byte count. An accepted last beat latches its keep, then go to ACK.
- ACK (1 cycle): data_ready_out=0; ack_o=1; output_data_len valid; issue RAM read of address 0; go to READ.
- READ: data_ready_out=0. Stream stored beats in order. tfirst is set on beat 0 and tlast on the final beat. After the tlast handshake, pulse output_done and return to IDLE.
- Byte count width is DATA_LENGTH_WIDTH. It saturates at all-ones and never wraps.
- Overflow: a beat arriving after 2^RAM_ADDR_WIDTH beats are stored is dropped, and err_o pulses once. The packet is still closed by last with the truncated beat count; the byte count excludes dropped beats.
- First while in WRITE: the partial packet is discarded and err_o pulses. That beat starts a new packet at address 0.
- Reset (synchronous, any state): the in-flight packet is discarded, FSM returns to IDLE, and RAM contents are don't-care.

## Timing
- Reset values: data_ready_out=1, ack_o=0, err_o=0, output_tvalid=0, output_tfirst=0, output_tlast=0, output_tkeep=0, output_tdata=0, output_data_len=0, output_done=0.
- ack_o is high the cycle after the last beat is accepted.
- RAM read latency is 1 cycle. The first output_tvalid rises the cycle after ack_o.
- At most one bubble per packet. With output_tready_in held high, the output is 1 beat/cycle.
- When output_tready_in is low, output_tdata, tkeep, tfirst and tlast hold stable and output_tvalid stays high. Use a prefetch/skid register so no beat is lost or duplicated.
- output_done is high the cycle after the tlast handshake. data_ready_out rises in that same cycle.

## Configuration
- OUTPUT_WRITER_LEN_CHECK_EN defined: data_len_in is latched on the first beat. At ACK it is compared with the counted length; on mismatch err_o pulses together with ack_o. Data is still replayed.
- Not defined: data_len_in is ignored, and err_o reports only overflow and restart.

## Test plan
- 4 beats (0xff, 0x100, 0x101, 0x120), last keep 8'he0, valid gaps of 3 cycles between beats → ack_o pulses once, output_data_len=27, and 4 output beats in order with tfirst on 0xff and tlast+tkeep=8'he0 on 0x120.
- Same packet with output_tready_in low for 1 cycle at beats 1 and 3 → identical output sequence, no duplicates, output_done one cycle after the last handshake.
- Single beat with first+last and keep 8'hff → output_data_len=8, one output beat with tfirst=tlast=1.
- RAM_ADDR_WIDTH=2, 6-beat packet → err_o pulses once, 4 beats replayed, output_data_len=32.
- New first after 2 beats without last, then a 3-beat packet → err_o pulses once, and only the 3-beat packet is replayed.
- With OUTPUT_WRITER_LEN_CHECK_EN: data_len_in=30 on the 27-byte packet → err_o and ack_o in the same cycle; data_len_in=27 → err_o stays 0.
